// File: rtl/smart_home_ctrl_p.sv
// Smart-home controller: debounced door/window/fire sensors and a temperature
// hysteresis band drive a priority FSM whose state one-hot decodes to actuators.
module smart_home_ctrl_p #(
  parameter int TEMP_W     = 7,
  parameter int DEB        = 4,
  parameter int ALARM_HOLD = 16,
  parameter int HEAT_ON    = 15,
  parameter int COOL_ON    = 50,
  parameter int HYST       = 2
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              SFD,
  input  logic              SRD,
  input  logic              SW,
  input  logic              SFA,
  input  logic [TEMP_W-1:0] ST,
  output logic              fdoor,
  output logic              rdoor,
  output logic              winbuzz,
  output logic              alarmbuzz,
  output logic              heater,
  output logic              cooler,
  output logic [2:0]        display
);

  if (COOL_ON - HYST <= HEAT_ON + HYST) begin : g_bad_thresholds
    $error("smart_home_ctrl_p: COOL_ON - HYST must exceed HEAT_ON + HYST");
  end

  localparam int DCW = (DEB > 1) ? $clog2(DEB) : 1;
  localparam int HCW = $clog2(ALARM_HOLD + 1);
  localparam logic [DCW-1:0] DEB_LAST  = DCW'(DEB - 1);
  localparam logic [HCW-1:0] HOLD_LOAD = HCW'(ALARM_HOLD);
  localparam logic [31:0] HEAT_SET = 32'(HEAT_ON);
  localparam logic [31:0] HEAT_CLR = 32'(HEAT_ON + HYST);
  localparam logic [31:0] COOL_SET = 32'(COOL_ON);
  localparam logic [31:0] COOL_CLR = 32'(COOL_ON - HYST);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    FDOOR  = 3'b001,
    RDOOR  = 3'b010,
    ALARM  = 3'b011,
    WINDOW = 3'b100,
    HEAT   = 3'b101,
    COOL   = 3'b110
  } state_t;

  state_t             state_q, state_next;
  logic [3:0]         raw, flag;
  logic [DCW-1:0]     cnt [4];
  logic [HCW-1:0]     hold;
  logic [TEMP_W-1:0]  st_q;
  logic [31:0]        st_ext;
  logic               heat_req, cool_req;
  logic               sfa_fall, alarm_req;

  // Index order: 0 front door, 1 rear door, 2 window, 3 fire.
  assign raw    = {SFA, SW, SRD, SFD};
  assign st_ext = 32'(st_q);

  // The hold must load on the same edge the fire flag drops, so ALARM never gaps.
  assign sfa_fall  = flag[3] & ~raw[3] & (cnt[3] == DEB_LAST);
  assign alarm_req = flag[3] | (hold != '0);

  always_ff @(posedge clk) begin
    if (Rst) begin
      flag <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (raw[i] != flag[i]) begin
          if (cnt[i] == DEB_LAST) begin
            flag[i] <= raw[i];
            cnt[i]  <= '0;
          end else begin
            cnt[i] <= cnt[i] + DCW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      hold <= '0;
    end else if (sfa_fall) begin
      hold <= HOLD_LOAD;
    end else if (flag[3]) begin
      hold <= '0;
    end else if (hold != '0) begin
      hold <= hold - HCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      st_q     <= '0;
      heat_req <= 1'b0;
      cool_req <= 1'b0;
    end else begin
      st_q <= ST;
      if (st_ext < HEAT_SET)       heat_req <= 1'b1;
      else if (st_ext >= HEAT_CLR) heat_req <= 1'b0;
      if (st_ext >= COOL_SET)      cool_req <= 1'b1;
      else if (st_ext < COOL_CLR)  cool_req <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    if (3'(state_q) == 3'b111) state_next = IDLE;
    else if (alarm_req)        state_next = ALARM;
    else if (flag[0])          state_next = FDOOR;
    else if (flag[1])          state_next = RDOOR;
    else if (flag[2])          state_next = WINDOW;
    else if (cool_req)         state_next = COOL;
    else if (heat_req)         state_next = HEAT;
  end

  always_comb begin
    fdoor     = 1'b0;
    rdoor     = 1'b0;
    winbuzz   = 1'b0;
    alarmbuzz = 1'b0;
    heater    = 1'b0;
    cooler    = 1'b0;
    case (state_q)
      FDOOR:   fdoor     = 1'b1;
      RDOOR:   rdoor     = 1'b1;
      ALARM:   alarmbuzz = 1'b1;
      WINDOW:  winbuzz   = 1'b1;
      HEAT:    heater    = 1'b1;
      COOL:    cooler    = 1'b1;
      default: ;
    endcase
  end

  assign display = state_q;

endmodule

// File: tb/tb_smart_home_ctrl_p.sv
// Bench for smart_home_ctrl_p: directed scenarios plus random sensor/temperature
// traffic, every cycle compared against a behavioural model of the controller.
module tb_smart_home_ctrl_p;

  localparam int DEB        = 4;
  localparam int ALARM_HOLD = 16;
  localparam int HEAT_ON    = 15;
  localparam int COOL_ON    = 50;
  localparam int HYST       = 2;

  logic       clk = 1'b0;
  logic       Rst, SFD, SRD, SW, SFA;
  logic [6:0] ST;
  logic       fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler;
  logic [2:0] display;

  int tests = 0;
  int fails = 0;

  // Behavioural model state.
  int m_cnt [4];
  bit m_flag [4];
  int m_hold;
  int m_stq;
  bit m_heat, m_cool;
  int m_state;

  smart_home_ctrl_p #(
    .TEMP_W(7), .DEB(DEB), .ALARM_HOLD(ALARM_HOLD),
    .HEAT_ON(HEAT_ON), .COOL_ON(COOL_ON), .HYST(HYST)
  ) dut (
    .clk(clk), .Rst(Rst), .SFD(SFD), .SRD(SRD), .SW(SW), .SFA(SFA), .ST(ST),
    .fdoor(fdoor), .rdoor(rdoor), .winbuzz(winbuzz), .alarmbuzz(alarmbuzz),
    .heater(heater), .cooler(cooler), .display(display)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] decode(input int s);
    case (s)
      1:       return 6'b100000;
      2:       return 6'b010000;
      3:       return 6'b001000;
      4:       return 6'b000100;
      5:       return 6'b000010;
      6:       return 6'b000001;
      default: return 6'b000000;
    endcase
  endfunction

  task automatic model_step();
    bit raw [4];
    bit nf [4];
    int nc [4];
    int ns;
    bit nh, nco;
    raw[0] = SFD; raw[1] = SRD; raw[2] = SW; raw[3] = SFA;
    if (Rst) begin
      for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_flag[i] = 0; end
      m_hold = 0; m_stq = 0; m_heat = 0; m_cool = 0; m_state = 0;
    end else begin
      if (m_flag[3] || m_hold > 0) ns = 3;
      else if (m_flag[0])          ns = 1;
      else if (m_flag[1])          ns = 2;
      else if (m_flag[2])          ns = 4;
      else if (m_cool)             ns = 6;
      else if (m_heat)             ns = 5;
      else                         ns = 0;
      nh = m_heat;
      if (m_stq < HEAT_ON) nh = 1; else if (m_stq >= HEAT_ON + HYST) nh = 0;
      nco = m_cool;
      if (m_stq >= COOL_ON) nco = 1; else if (m_stq < COOL_ON - HYST) nco = 0;
      for (int i = 0; i < 4; i++) begin
        nf[i] = m_flag[i];
        nc[i] = 0;
        if (raw[i] != m_flag[i]) begin
          nc[i] = m_cnt[i] + 1;
          if (nc[i] == DEB) begin nf[i] = raw[i]; nc[i] = 0; end
        end
      end
      if (m_flag[3] && !nf[3]) m_hold = ALARM_HOLD;
      else if (m_flag[3])      m_hold = 0;
      else if (m_hold > 0)     m_hold = m_hold - 1;
      for (int i = 0; i < 4; i++) begin m_flag[i] = nf[i]; m_cnt[i] = nc[i]; end
      m_heat = nh; m_cool = nco; m_state = ns;
      m_stq = int'(ST);
    end
  endtask

  task automatic check_model();
    logic [5:0] outs;
    outs = {fdoor, rdoor, alarmbuzz, winbuzz, heater, cooler};
    tests++;
    assert (display === 3'(m_state)) else begin
      fails++;
      $error("FAIL model_display: observed %b expected %b at %0t", display, 3'(m_state), $time);
    end
    tests++;
    assert (outs === decode(m_state)) else begin
      fails++;
      $error("FAIL model_outs: observed %b expected %b at %0t", outs, decode(m_state), $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic expect_state(input string tag, input logic [2:0] d, input logic [5:0] o);
    logic [5:0] outs;
    outs = {fdoor, rdoor, alarmbuzz, winbuzz, heater, cooler};
    tests++;
    assert (display === d && outs === o) else begin
      fails++;
      $error("FAIL %s: observed display=%b outs=%b expected display=%b outs=%b",
             tag, display, outs, d, o);
    end
  endtask

  initial begin
    Rst = 1'b1; SFD = 1'b0; SRD = 1'b0; SW = 1'b0; SFA = 1'b0; ST = 7'd30;
    tick_n(2);
    expect_state("reset", 3'b000, 6'b000000);
    Rst = 1'b0;
    tick_n(6);
    expect_state("settle", 3'b000, 6'b000000);

    // Front door debounce latency and short-pulse rejection.
    SFD = 1'b1;
    tick_n(4);
    expect_state("fdoor_edge4", 3'b000, 6'b000000);
    tick();
    expect_state("fdoor_edge5", 3'b001, 6'b100000);
    SFD = 1'b0;
    tick_n(6);
    SFD = 1'b1;
    tick_n(3);
    SFD = 1'b0;
    tick_n(6);
    expect_state("fdoor_pulse3", 3'b000, 6'b000000);

    // All sensors together, then fire alarm hold.
    SFD = 1'b1; SRD = 1'b1; SW = 1'b1; SFA = 1'b1;
    tick_n(5);
    expect_state("all_alarm", 3'b011, 6'b001000);
    SFA = 1'b0;
    tick_n(20);
    expect_state("hold_last", 3'b011, 6'b001000);
    tick();
    expect_state("hold_done", 3'b001, 6'b100000);
    SFD = 1'b0; SRD = 1'b0; SW = 1'b0;
    tick_n(6);
    expect_state("all_clear", 3'b000, 6'b000000);

    // Heater hysteresis.
    for (int t = 20; t >= 14; t--) begin ST = 7'(t); tick(); end
    tick_n(2);
    expect_state("heat_on14", 3'b101, 6'b000010);
    ST = 7'd16; tick_n(5);
    expect_state("heat_hold16", 3'b101, 6'b000010);
    ST = 7'd17; tick_n(3);
    expect_state("heat_off17", 3'b000, 6'b000000);

    // Cooler hysteresis.
    for (int t = 40; t <= 50; t++) begin ST = 7'(t); tick(); end
    tick_n(2);
    expect_state("cool_on50", 3'b110, 6'b000001);
    ST = 7'd48; tick_n(5);
    expect_state("cool_hold48", 3'b110, 6'b000001);
    ST = 7'd47; tick_n(3);
    expect_state("cool_off47", 3'b000, 6'b000000);

    // Window outranks cooling.
    ST = 7'd60; tick_n(3);
    expect_state("cool_60", 3'b110, 6'b000001);
    SW = 1'b1; tick_n(5);
    expect_state("window_over_cool", 3'b100, 6'b000100);
    SW = 1'b0; tick_n(4);
    expect_state("window_fall4", 3'b100, 6'b000100);
    tick();
    expect_state("cool_back", 3'b110, 6'b000001);

    // Reset in the middle of an alarm hold.
    SFA = 1'b1; tick_n(5);
    expect_state("alarm_again", 3'b011, 6'b001000);
    SFA = 1'b0; tick_n(7);
    expect_state("in_hold", 3'b011, 6'b001000);
    Rst = 1'b1; SFA = 1'b1;
    tick();
    expect_state("reset_in_hold", 3'b000, 6'b000000);
    Rst = 1'b0;
    tick_n(4);
    expect_state("post_reset4", 3'b110, 6'b000001);
    tick();
    expect_state("post_reset5", 3'b011, 6'b001000);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(5, 0) == 0) SFD = ~SFD;
      if ($urandom_range(5, 0) == 0) SRD = ~SRD;
      if ($urandom_range(5, 0) == 0) SW  = ~SW;
      if ($urandom_range(7, 0) == 0) SFA = ~SFA;
      if ($urandom_range(7, 0) == 0) ST  = 7'($urandom_range(127, 0));
      Rst = ($urandom_range(99, 0) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
